// File: rtl/uart_mmio_bridge_if.sv
// CPU data-bus view of the UART register window: address/store/load strobes and load data.
interface uart_mmio_bridge_if;
  logic [31:0] address;
  logic [31:0] WD;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] RD;

  modport master (output address, WD, mem_write, mem_read, input RD);
  modport slave  (input address, WD, mem_write, mem_read, output RD);
endinterface

// File: rtl/uart_mmio_bridge.sv
// MMIO register bridge: TX FIFO drained one frame at a time into the UART,
// RX FIFO filled by the receiver and popped by RXDATA loads.
module uart_mmio_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_mmio_bridge_if.slave    bus,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  input  logic [7:0]           rx_data,
  input  logic                 rx_done,
  output logic                 irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic       sel;
  logic [1:0] off;
  assign sel = (bus.address[31:4] == BASE_ADDR[31:4]);
  assign off = bus.address[3:2];

  logic unused_bits;
  assign unused_bits = ^{bus.WD[31:8], bus.address[1:0]};

  logic wr_tx, wr_st, wr_ctl, rd_rx;
  assign wr_tx  = sel & bus.mem_write & (off == 2'd0);
  assign wr_st  = sel & bus.mem_write & (off == 2'd2);
  assign wr_ctl = sel & bus.mem_write & (off == 2'd3);
  assign rd_rx  = sel & bus.mem_read  & (off == 2'd1);

  // ---------------- TX FIFO ----------------
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0]   tx_lvl;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_ovf;
  logic [0:0] state;

  assign tx_full  = (tx_lvl == (TAW+1)'(TX_DEPTH));
  assign tx_empty = (tx_lvl == '0);
  assign tx_pop   = (state == ST_IDLE) & ~tx_empty;
  // a store into a full FIFO still lands when the FSM frees a slot that cycle
  assign tx_push  = wr_tx & (~tx_full | tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.WD[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TAW'(1);
      if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_lvl <= tx_lvl + (TAW+1)'(1);
        2'b01:   tx_lvl <= tx_lvl - (TAW+1)'(1);
        default: tx_lvl <= tx_lvl;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: if (tx_pop) begin
          tx_data  <= tx_mem[tx_rp];
          tx_start <= 1'b1;
          state    <= ST_WAIT;
        end
        // a done coincident with the launch pulse belongs to no frame of ours
        ST_WAIT: if (tx_done && !tx_start) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0]   rx_lvl;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_ovf;

  assign rx_full  = (rx_lvl == (RAW+1)'(RX_DEPTH));
  assign rx_empty = (rx_lvl == '0);
  assign rx_pop   = rd_rx & ~rx_empty;
  assign rx_push  = rx_done & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RAW'(1);
      if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_lvl <= rx_lvl + (RAW+1)'(1);
        2'b01:   rx_lvl <= rx_lvl - (RAW+1)'(1);
        default: rx_lvl <= rx_lvl;
      endcase
    end
  end

  // ---------------- flags, CTRL, irq ----------------
  logic [1:0] ctrl;
  logic tx_busy;
  assign tx_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
      ctrl   <= 2'b00;
      irq    <= 1'b0;
    end else begin
      // set outranks a simultaneous W1C
      if (wr_tx & tx_full & ~tx_pop)       tx_ovf <= 1'b1;
      else if (wr_st & bus.WD[5])          tx_ovf <= 1'b0;
      if (rx_done & rx_full & ~rx_pop)     rx_ovf <= 1'b1;
      else if (wr_st & bus.WD[6])          rx_ovf <= 1'b0;
      if (wr_ctl) ctrl <= bus.WD[1:0];
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy);
    end
  end

  logic [31:0] status;
  assign status = {16'h0000, 4'(rx_lvl), 4'(tx_lvl), 1'b0, rx_ovf, tx_ovf,
                   tx_busy, rx_full, ~rx_empty, tx_empty, tx_full};

  logic [31:0] rd_val;
  always_comb begin
    rd_val = 32'h0;
    if (sel) begin
      case (off)
        2'd1:    rd_val = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rp]};
        2'd2:    rd_val = status;
        2'd3:    rd_val = {30'h0, ctrl};
        default: rd_val = 32'h0;
      endcase
    end
  end
  assign bus.RD = rd_val;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge: TX bytes checked at each tx_start, RX bytes at each RXDATA load.
module tb_uart_mmio_bridge;
  localparam logic [31:0] A_TX = 32'h1000, A_RX = 32'h1004, A_ST = 32'h1008, A_CT = 32'h100C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       irq;

  uart_mmio_bridge_if bus();

  uart_mmio_bridge dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .rx_data(rx_data), .rx_done(rx_done), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int nstart = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // every launched frame must match the oldest accepted store
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      nstart++;
      if (txq.size() == 0) chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                 chk("tx_data", {24'h0, tx_data}, {24'h0, txq.pop_front()});
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.WD = d; bus.mem_write = 1'b1;
    @(negedge clk);
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.mem_read = 1'b1;
    #1 d = bus.RD;
    @(negedge clk);
    bus.mem_read = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_done;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, tx_start}, 32'd1);
  endtask

  task automatic rx_load(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    e = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
    rd(A_RX, d);
    chk(tag, d, {24'h0, e});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int ns;
    rst_n = 1'b0; tx_done = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
    bus.address = 32'h0; bus.WD = 32'h0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    rd(A_ST, d);      chk("rst_status", d, 32'h0000_0002);
    chk("rst_irq",      {31'h0, irq},      32'd0);
    chk("rst_tx_start", {31'h0, tx_start}, 32'd0);
    chk("rst_tx_data",  {24'h0, tx_data},  32'd0);
    rd(A_TX, d);      chk("txdata_read", d, 32'h0);
    wr(32'h2000, 32'h55); wr(32'h2004, 32'h0);
    rd(32'h2008, d);  chk("unmapped_rd", d, 32'h0);
    chk("unmapped_nostart", {31'h0, tx_start}, 32'd0);

    // single byte, latency and busy
    txq.push_back(8'hA5);
    wr(A_TX, 32'hA5);
    chk("lat_edge1", {31'h0, tx_start}, 32'd0);
    @(negedge clk);
    chk("lat_edge2", {31'h0, tx_start}, 32'd1);
    rd(A_ST, d);      chk("busy_status", d, 32'h0000_0012);
    pulse_done;
    rd(A_ST, d);      chk("idle_status", d, 32'h0000_0002);

    // overflow: byte 1 in flight, 2..9 buffered, 10 dropped
    txq.push_back(8'd1);
    wr(A_TX, 32'd1);
    wait_start("ovf_first_start");
    for (int i = 2; i <= 10; i++) begin
      if (i <= 9) txq.push_back(8'(i));
      wr(A_TX, 32'(i));
    end
    rd(A_ST, d);      chk("tx_full_status", d, 32'h0000_0831);
    for (int i = 0; i < 9; i++) begin
      pulse_done;
      if (i < 8) wait_start("ovf_drain_start");
    end
    repeat (3) @(negedge clk);
    chk("txq_drained", 32'(txq.size()), 32'd0);
    rd(A_ST, d);      chk("tx_ovf_sticky", d, 32'h0000_0022);
    wr(A_ST, 32'h20);
    rd(A_ST, d);      chk("tx_ovf_w1c", d, 32'h0000_0002);

    // RX basic
    rxq.push_back(8'h3C); rx_pulse(8'h3C);
    rxq.push_back(8'hC3); rx_pulse(8'hC3);
    rd(A_ST, d);      chk("rx_lvl2", d, 32'h0000_2006);
    rx_load("rx_first");
    rx_load("rx_second");
    rx_load("rx_empty_load");
    rd(A_ST, d);      chk("rx_lvl0", d, 32'h0000_0002);

    // RX full with simultaneous load, then overflow
    for (int i = 0; i < 8; i++) begin
      rxq.push_back(8'(8'h10 + i));
      rx_pulse(8'(8'h10 + i));
    end
    rd(A_ST, d);      chk("rx_full_status", d, 32'h0000_800E);
    @(negedge clk);
    bus.address = A_RX; bus.mem_read = 1'b1; rx_data = 8'h77; rx_done = 1'b1;
    #1 chk("rx_full_pop", bus.RD, {24'h0, rxq.pop_front()});
    rxq.push_back(8'h77);
    @(negedge clk);
    bus.mem_read = 1'b0; rx_done = 1'b0;
    rd(A_ST, d);      chk("rx_push_pop_full", d, 32'h0000_800E);
    rx_pulse(8'h88);
    rd(A_ST, d);      chk("rx_ovf_set", d, 32'h0000_804E);
    for (int i = 0; i < 8; i++) rx_load("rx_drain");
    wr(A_ST, 32'h40);
    rd(A_ST, d);      chk("rx_ovf_w1c", d, 32'h0000_0002);

    // rx irq
    wr(A_CT, 32'h1);
    rd(A_CT, d);      chk("ctrl_rd", d, 32'h1);
    chk("irq_idle", {31'h0, irq}, 32'd0);
    rxq.push_back(8'h5A); rx_pulse(8'h5A);
    chk("irq_lag", {31'h0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_set", {31'h0, irq}, 32'd1);
    rx_load("irq_rx_byte");
    @(negedge clk);
    chk("irq_clr", {31'h0, irq}, 32'd0);

    // reset mid-WAIT with buffered bytes and irq high
    rxq.push_back(8'h99); rx_pulse(8'h99);
    txq.push_back(8'h41); wr(A_TX, 32'h41);
    wr(A_TX, 32'h42);
    wr(A_TX, 32'h43);
    chk("pre_rst_irq", {31'h0, irq}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_data", {24'h0, tx_data}, 32'd0);
    chk("arst_irq",     {31'h0, irq},     32'd0);
    rxq.delete(); txq.delete();
    @(negedge clk); rst_n = 1'b1;
    rd(A_ST, d);      chk("post_rst_status", d, 32'h0000_0002);

    // reset while tx_start is high; later stray tx_done ignored
    txq.push_back(8'h50); wr(A_TX, 32'h50);
    wait_start("pre_rst_start");
    #1 rst_n = 1'b0;
    #1 chk("arst_tx_start", {31'h0, tx_start}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    ns = nstart;
    pulse_done;
    repeat (4) @(negedge clk);
    chk("stray_done_nostart", 32'(nstart), 32'(ns));
    rd(A_ST, d);      chk("stray_done_status", d, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
